// File: rtl/seq_unsigned_divider.sv
// Sequential restoring unsigned divider producing one quotient bit per clock.
// Its trial subtractor is a chain of 4-bit carry-lookahead groups.

module seq_unsigned_divider_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every carry is formed directly from generate/propagate terms rather than rippling.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

module seq_unsigned_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NG = WIDTH / 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ZERO
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_calc_last;
  logic             w_zero_done;

  // The dividend register doubles as the quotient accumulator: dividend bits shift
  // out of the top while quotient bits shift into the bottom.
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_divisor_n;
  logic [WIDTH-1:0] w_diff;
  logic [NG:0]      w_carry;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;

  assign w_shift     = {r_rem, r_dividend[WIDTH-1]};
  assign w_divisor_n = ~r_divisor;
  assign w_carry[0]  = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NG; g++) begin : g_cla
      seq_unsigned_divider_cla4 u_cla (
        .i_a    (w_shift[4*g +: 4]),
        .i_b    (w_divisor_n[4*g +: 4]),
        .i_cin  (w_carry[g]),
        .o_sum  (w_diff[4*g +: 4]),
        .o_cout (w_carry[g+1])
      );
    end
  endgenerate

  // The top trial bit adds an inverted zero (a one), so its carry-out is a OR carry-in.
  // Its sum bit is always zero whenever the subtraction succeeds, so it is never formed.
  assign w_no_borrow = w_shift[WIDTH] | w_carry[NG];
  assign w_rem_next  = w_no_borrow ? w_diff : w_shift[WIDTH-1:0];
  assign w_quot_next = {r_dividend[WIDTH-2:0], w_no_borrow};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_calc_last  = 1'b0;
    w_zero_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept     = 1'b1;
          w_next_state = (Divisor == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        if (r_count == '0) begin
          w_calc_last  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_ZERO: begin
        w_zero_done  = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= w_calc_last | w_zero_done;
      if (w_accept) begin
        r_dividend <= Dividend;
        r_divisor  <= Divisor;
        r_rem      <= '0;
        r_count    <= CW'(WIDTH - 1);
      end else if (r_state == S_CALC) begin
        r_dividend <= w_quot_next;
        r_rem      <= w_rem_next;
        r_count    <= r_count - 1'b1;
      end
      if (w_calc_last) begin
        r_quotient  <= w_quot_next;
        r_remainder <= w_rem_next;
        r_dbz       <= 1'b0;
      end else if (w_zero_done) begin
        r_quotient  <= '1;
        r_remainder <= r_dividend;
        r_dbz       <= 1'b1;
      end
    end
  end

  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;
  assign DivByZero = r_dbz;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Scoreboard bench for seq_unsigned_divider (WIDTH=8): the driver queues expected
// results and the negedge monitor checks them whenever Done is seen.

module tb_seq_unsigned_divider;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivByZero;

  seq_unsigned_divider #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prevDone = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every Done pulse must match the oldest queued expectation and be one cycle wide.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prevDone = 1'b0;
    end else begin
      if (Done) begin
        checkOutput("doneWidth", 32'(prevDone), 32'd0);
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got Done with no pending divide (cycle %0d)", cyc);
        end else begin
          mon = sbQ.pop_front();
          checkOutput("quotient", 32'(Quotient), 32'(mon.q));
          checkOutput("remainder", 32'(Remainder), 32'(mon.r));
          checkOutput("divByZero", 32'(DivByZero), 32'(mon.z));
          checkOutput("doneCycle", 32'(cyc), 32'(mon.cyc));
        end
      end
      prevDone = Done;
    end
  end

  // Called at a negedge; issues one divide and returns at the negedge where Done is seen.
  task automatic applyStimulus(input logic [7:0] dd, input logic [7:0] dv,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic ez, input bit noise);
    exp_t e;
    int   n;
    int   busyCnt;
    n = 0;
    while (Busy && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) checkOutput("idleTimeout", 32'(Busy), 32'd0);
    Start    = 1'b1;
    Dividend = dd;
    Divisor  = dv;
    e.q   = eq;
    e.r   = er;
    e.z   = ez;
    e.cyc = cyc + 1 + (ez ? 1 : 8);
    sbQ.push_back(e);
    @(posedge Clk);
    #1;
    Start    = 1'b0;
    Dividend = 8'($urandom_range(0, 255));
    Divisor  = 8'($urandom_range(0, 255));
    @(negedge Clk);
    n = 0;
    busyCnt = 0;
    while (!Done && n < 30) begin
      if (Busy) busyCnt++;
      if (noise) begin
        Start    = 1'b1;
        Dividend = 8'($urandom_range(0, 255));
        Divisor  = 8'($urandom_range(0, 255));
      end
      n++;
      @(negedge Clk);
    end
    Start = 1'b0;
    if (!Done) checkOutput("doneTimeout", 32'(Done), 32'd1);
    checkOutput("busyCycles", 32'(busyCnt), ez ? 32'd1 : 32'd8);
    checkOutput("busyAtDone", 32'(Busy), 32'd0);
  endtask

  initial begin
    int   n;
    logic [7:0] rd;
    logic [7:0] rv;
    Rst_n    = 1'b0;
    Start    = 1'b0;
    Dividend = 8'd0;
    Divisor  = 8'd0;
    repeat (3) @(negedge Clk);
    checkOutput("resetQuotient", 32'(Quotient), 32'd0);
    checkOutput("resetRemainder", 32'(Remainder), 32'd0);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetDone", 32'(Done), 32'd0);
    checkOutput("resetDbz", 32'(DivByZero), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    applyStimulus(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0);
    applyStimulus(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0);
    applyStimulus(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 1'b0);
    applyStimulus(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 1'b0);
    applyStimulus(8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1'b0);
    applyStimulus(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0);
    applyStimulus(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0);
    applyStimulus(8'd254, 8'd16,  8'd15,  8'd14,  1'b0, 1'b0);
    applyStimulus(8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 1'b0);
    applyStimulus(8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1'b0);
    applyStimulus(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b1);
    applyStimulus(8'd250, 8'd13,  8'd19,  8'd3,   1'b0, 1'b1);

    // Abort an in-flight divide with reset four cycles in.
    Start    = 1'b1;
    Dividend = 8'd50;
    Divisor  = 8'd6;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    checkOutput("abortQuotient", 32'(Quotient), 32'd0);
    checkOutput("abortRemainder", 32'(Remainder), 32'd0);
    checkOutput("abortBusy", 32'(Busy), 32'd0);
    checkOutput("abortDone", 32'(Done), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (12) @(negedge Clk);
    applyStimulus(8'd77, 8'd10, 8'd7, 8'd7, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom_range(0, 255));
      rv = (i % 10 == 9) ? 8'd0 : 8'($urandom_range(1, 255));
      if (rv == 8'd0) applyStimulus(rd, rv, 8'd255, rd, 1'b1, 1'b0);
      else            applyStimulus(rd, rv, rd / rv, rd % rv, 1'b0, 1'b0);
    end

    n = 0;
    while (sbQ.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
